// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one memory port between instruction fetch and load/store.
// Data side wins ties, bounded by a streak counter so a waiting fetch cannot starve.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ack,
    output logic [DATA_W-1:0]     i_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_sel,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_sel,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  stallreq_if,
    output logic                  stallreq_mem
);

    localparam int unsigned SEL_W      = DATA_W / 8;
    localparam logic [3:0]  STREAK_MAX = 4'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [3:0]          d_streak_q,  d_streak_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [SEL_W-1:0]    mem_sel_q,   mem_sel_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                grant_d;
    logic                grant_i;

    // Data wins unless a fetch is waiting and data has already had its streak.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state_q == IDLE) begin
            grant_d = d_req && (!i_req || (d_streak_q < STREAK_MAX));
            grant_i = !grant_d && i_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            d_streak_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            d_streak_q  <= d_streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        d_streak_d  = d_streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = DBUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_sel_d   = d_sel;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (!i_req) begin
                        d_streak_d = '0;
                    end else if (d_streak_q >= STREAK_MAX) begin
                        d_streak_d = STREAK_MAX;
                    end else begin
                        d_streak_d = d_streak_q + 4'd1;
                    end
                end else if (grant_i) begin
                    state_d     = IBUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_sel_d   = '1;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    d_streak_d  = '0;
                end
            end
            IBUSY, DBUSY: begin
                // Bus fields are held untouched; only the request drops on completion.
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_sel   = mem_sel_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign i_ack   = (state_q == IBUSY) && mem_ack;
    assign d_ack   = (state_q == DBUSY) && mem_ack;
    assign i_rdata = i_ack ? mem_rdata : '0;
    assign d_rdata = d_ack ? mem_rdata : '0;

    assign stallreq_if  = i_req && !i_ack;
    assign stallreq_mem = d_req && !d_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: cycle table for fetch/store/collision,
// plus hand sequences for streak limiting and mid-transaction reset.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we, mem_ack;
    logic [AW-1:0] i_addr, d_addr;
    logic [3:0]    d_sel;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          i_ack, d_ack, mem_req, mem_we, stallreq_if, stallreq_mem;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [3:0]    mem_sel;
    logic [AW-1:0] mem_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MAX_D_STREAK(4)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
    );

    typedef struct {
        logic        ireq;  logic [31:0] iaddr;
        logic        dreq;  logic dwe; logic [3:0] dsel; logic [31:0] daddr; logic [31:0] dwdata;
        logic        mack;  logic [31:0] mrdata;
        logic        ereq;  logic chk; logic ewe; logic [3:0] esel; logic [31:0] eaddr; logic [31:0] ewdata;
        logic        eiack; logic [31:0] eird;
        logic        edack; logic [31:0] edrd;
        logic        esif;  logic esmem;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_sel = '0;
        d_addr = '0; d_wdata = '0; mem_ack = 0; mem_rdata = '0;
    endtask

    logic [31:0] starve_exp [6];
    logic        starve_isd [6];

    initial begin
        // c0-c4 fetch (ack 3 cycles after mem_req), c5-c8 store + ignored IDLE ack,
        // c9-c14 collision with zero-wait D then I after one IDLE cycle.
        vt[0]  = '{1,32'h4,0,0,4'h0,32'h0,32'h0,0,32'h0,          0,1,0,4'h0,32'h0,32'h0,         0,32'h0,0,32'h0,1,0};
        vt[1]  = '{1,32'h4,0,0,4'h0,32'h0,32'h0,0,32'h0,          1,1,0,4'hF,32'h4,32'h0,         0,32'h0,0,32'h0,1,0};
        vt[2]  = '{1,32'h4,0,0,4'h0,32'h0,32'h0,0,32'hFFFF_FFFF,  1,1,0,4'hF,32'h4,32'h0,         0,32'h0,0,32'h0,1,0};
        vt[3]  = '{1,32'h4,0,0,4'h0,32'h0,32'h0,0,32'h0,          1,1,0,4'hF,32'h4,32'h0,         0,32'h0,0,32'h0,1,0};
        vt[4]  = '{1,32'h4,0,0,4'h0,32'h0,32'h0,1,32'h3401_0020,  1,1,0,4'hF,32'h4,32'h0,         1,32'h3401_0020,0,32'h0,0,0};
        vt[5]  = '{0,32'h0,1,1,4'h3,32'h100,32'hDEAD_BEEF,0,32'h0, 0,0,0,4'h0,32'h0,32'h0,        0,32'h0,0,32'h0,0,1};
        vt[6]  = '{0,32'h0,1,1,4'h3,32'h100,32'hDEAD_BEEF,0,32'h0, 1,1,1,4'h3,32'h100,32'hDEAD_BEEF,0,32'h0,0,32'h0,0,1};
        vt[7]  = '{0,32'h0,1,1,4'h3,32'h100,32'hDEAD_BEEF,1,32'h1234_5678, 1,1,1,4'h3,32'h100,32'hDEAD_BEEF,0,32'h0,1,32'h1234_5678,0,0};
        vt[8]  = '{0,32'h0,0,0,4'h0,32'h0,32'h0,1,32'hFFFF_FFFF,  0,0,0,4'h0,32'h0,32'h0,         0,32'h0,0,32'h0,0,0};
        vt[9]  = '{1,32'h200,1,0,4'hF,32'h300,32'h0,0,32'h0,      0,0,0,4'h0,32'h0,32'h0,         0,32'h0,0,32'h0,1,1};
        vt[10] = '{1,32'h200,1,0,4'hF,32'h300,32'h0,1,32'hAAAA_5555, 1,1,0,4'hF,32'h300,32'h0,    0,32'h0,1,32'hAAAA_5555,1,0};
        vt[11] = '{1,32'h200,0,0,4'h0,32'h0,32'h0,0,32'h0,        0,0,0,4'h0,32'h0,32'h0,         0,32'h0,0,32'h0,1,0};
        vt[12] = '{1,32'h200,0,0,4'h0,32'h0,32'h0,0,32'h0,        1,1,0,4'hF,32'h200,32'h0,       0,32'h0,0,32'h0,1,0};
        vt[13] = '{1,32'h200,0,0,4'h0,32'h0,32'h0,1,32'h0BAD_F00D, 1,1,0,4'hF,32'h200,32'h0,      1,32'h0BAD_F00D,0,32'h0,0,0};
        vt[14] = '{0,32'h0,0,0,4'h0,32'h0,32'h0,0,32'h0,          0,0,0,4'h0,32'h0,32'h0,         0,32'h0,0,32'h0,0,0};

        starve_exp = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h500, 32'h400};
        starve_isd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state, with requests and a stray mem_ack present.
        rst = 1'b0;
        drive_idle();
        i_req = 1; mem_ack = 1; mem_rdata = 32'hCAFE_0001;
        @(negedge clk); @(negedge clk); #2;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_sel", 32'(mem_sel), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_i_ack", 32'(i_ack), 32'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_stall_if", 32'(stallreq_if), 32'h1);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;

        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            i_req = vt[k].ireq; i_addr = vt[k].iaddr;
            d_req = vt[k].dreq; d_we = vt[k].dwe; d_sel = vt[k].dsel;
            d_addr = vt[k].daddr; d_wdata = vt[k].dwdata;
            mem_ack = vt[k].mack; mem_rdata = vt[k].mrdata;
            #2;
            chk($sformatf("v%0d_mem_req", k), 32'(mem_req), 32'(vt[k].ereq));
            if (vt[k].chk) begin
                chk($sformatf("v%0d_mem_we", k), 32'(mem_we), 32'(vt[k].ewe));
                chk($sformatf("v%0d_mem_sel", k), 32'(mem_sel), 32'(vt[k].esel));
                chk($sformatf("v%0d_mem_addr", k), mem_addr, vt[k].eaddr);
                chk($sformatf("v%0d_mem_wdata", k), mem_wdata, vt[k].ewdata);
            end
            chk($sformatf("v%0d_i_ack", k), 32'(i_ack), 32'(vt[k].eiack));
            chk($sformatf("v%0d_i_rdata", k), i_rdata, vt[k].eird);
            chk($sformatf("v%0d_d_ack", k), 32'(d_ack), 32'(vt[k].edack));
            chk($sformatf("v%0d_d_rdata", k), d_rdata, vt[k].edrd);
            chk($sformatf("v%0d_stall_if", k), 32'(stallreq_if), 32'(vt[k].esif));
            chk($sformatf("v%0d_stall_mem", k), 32'(stallreq_mem), 32'(vt[k].esmem));
        end

        // Streak limit: fetch held, data always requesting, zero-wait memory.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                i_req = 1; i_addr = 32'h500;
                d_req = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h400; d_wdata = '0;
                mem_ack = 1; mem_rdata = 32'h77;
            end
            #2;
            chk($sformatf("starve%0d_idle", k), 32'(mem_req), 32'h0);
            @(negedge clk); #2;
            chk($sformatf("starve%0d_req", k), 32'(mem_req), 32'h1);
            chk($sformatf("starve%0d_addr", k), mem_addr, starve_exp[k]);
            chk($sformatf("starve%0d_d_ack", k), 32'(d_ack), 32'(starve_isd[k]));
            chk($sformatf("starve%0d_i_ack", k), 32'(i_ack), 32'(!starve_isd[k]));
        end
        @(negedge clk);
        drive_idle();
        #2;
        chk("starve_end_idle", 32'(mem_req), 32'h0);

        // Reset while DBUSY abandons the store; grant resumes after release.
        @(negedge clk);
        d_req = 1; d_we = 1; d_sel = 4'hF; d_addr = 32'h600; d_wdata = 32'h55;
        #2;
        @(negedge clk); #2;
        chk("rmid_busy", 32'(mem_req), 32'h1);
        #1;
        rst = 1'b0; mem_ack = 1; mem_rdata = 32'h9999_9999;
        #1;
        chk("rmid_req_async", 32'(mem_req), 32'h0);
        chk("rmid_addr_async", mem_addr, 32'h0);
        chk("rmid_we_async", 32'(mem_we), 32'h0);
        chk("rmid_d_ack", 32'(d_ack), 32'h0);
        chk("rmid_d_rdata", d_rdata, 32'h0);
        chk("rmid_stall_mem", 32'(stallreq_mem), 32'h1);
        @(negedge clk); #2;
        chk("rmid_held", 32'(mem_req), 32'h0);
        rst = 1'b1; mem_ack = 0;
        #1;
        chk("rmid_no_early_grant", 32'(mem_req), 32'h0);
        @(negedge clk); #2;
        chk("rmid_regrant_req", 32'(mem_req), 32'h1);
        chk("rmid_regrant_addr", mem_addr, 32'h600);
        mem_ack = 1; mem_rdata = 32'h0000_0042;
        #1;
        chk("rmid_final_d_ack", 32'(d_ack), 32'h1);
        chk("rmid_final_rdata", d_rdata, 32'h0000_0042);
        @(negedge clk);
        drive_idle();
        #2;
        chk("rmid_final_idle", 32'(mem_req), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
